// File: rtl/fixed_subframe_controller.sv
// Sequencing controller for a fixed-predictor subframe decoder.
// Drives the datapath clear/enable and tracks samples through its pipe.
module fixed_subframe_controller #(
    parameter int PIPE_LATENCY = 3,
    parameter int BLOCK_W      = 16
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iStart,
    input  logic [2:0]         iOrder,
    input  logic [BLOCK_W-1:0] iBlockSize,
    input  logic               iResidualValid,
    output logic               oResidualReady,
    output logic               oWarmup,
    output logic               oDecReset,
    output logic               oDecEnable,
    output logic [2:0]         oDecOrder,
    output logic               oOutValid,
    output logic [BLOCK_W-1:0] oSampleCount,
    output logic               oBusy,
    output logic               oDone,
    output logic               oError
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [2:0]              order_q, order_d;
    logic [BLOCK_W-1:0]      block_q, block_d;
    logic [BLOCK_W-1:0]      in_cnt_q, in_cnt_d;
    logic [BLOCK_W-1:0]      out_cnt_q, out_cnt_d;
    logic [PIPE_LATENCY-1:0] tag_q, tag_d;
    logic                    out_valid_q, out_valid_d;
    logic                    error_q, error_d;

    logic start_ok;
    logic accept;
    logic ready;
    logic warmup;
    logic dec_reset;
    logic dec_enable;
    logic done;

    // Next-state, counter and tag-pipe logic for the subframe sequence.
    always_comb begin
        state_d     = state_q;
        order_d     = order_q;
        block_d     = block_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        tag_d       = tag_q;
        out_valid_d = 1'b0;
        error_d     = 1'b0;
        accept      = 1'b0;
        ready       = 1'b0;
        warmup      = 1'b0;
        dec_reset   = 1'b0;
        dec_enable  = 1'b0;
        done        = 1'b0;
        start_ok    = (iOrder <= 3'd4) && (iBlockSize != '0)
                   && (BLOCK_W'(iOrder) <= iBlockSize);

        unique case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    if (start_ok) begin
                        order_d = iOrder;
                        block_d = iBlockSize;
                        state_d = S_CLEAR;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                dec_reset = 1'b1;
                in_cnt_d  = '0;
                out_cnt_d = '0;
                tag_d     = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                ready      = 1'b1;
                accept     = iResidualValid;
                dec_enable = iResidualValid;
                warmup     = accept && (in_cnt_q < BLOCK_W'(order_q));
                if (accept) begin
                    in_cnt_d = in_cnt_q + BLOCK_W'(1);
                    if (in_cnt_d == block_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                dec_enable = 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A tag reaching the last stage marks a decoded sample at the output.
        if (dec_enable) begin
            tag_d       = {tag_q[PIPE_LATENCY-2:0], accept};
            out_valid_d = tag_q[PIPE_LATENCY-2];
        end
        if (out_valid_d) begin
            out_cnt_d = out_cnt_q + BLOCK_W'(1);
        end
        if (state_q == S_DRAIN && out_cnt_d == block_q) begin
            state_d = S_DONE;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q     <= S_IDLE;
            order_q     <= '0;
            block_q     <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            order_q     <= order_d;
            block_q     <= block_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
            error_q     <= error_d;
        end
    end

    assign oResidualReady = ready;
    assign oWarmup        = warmup;
    assign oDecReset      = dec_reset;
    assign oDecEnable     = dec_enable;
    assign oDecOrder      = order_q;
    assign oOutValid      = out_valid_q;
    assign oSampleCount   = out_cnt_q;
    assign oBusy          = (state_q != S_IDLE);
    assign oDone          = done;
    assign oError         = error_q;

endmodule

// File: tb/tb_fixed_subframe_controller.sv
// Testbench for fixed_subframe_controller: randomized valid streams
// checked cycle by cycle against a schedule-based reference model.
module tb_fixed_subframe_controller;

    localparam int LAT = 3;
    localparam int BW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    ord;
    logic [BW-1:0] blk;
    logic          rv;
    logic          o_ready, o_warm, o_dres, o_en, o_outv, o_busy, o_done, o_err;
    logic [2:0]    o_order;
    logic [BW-1:0] o_cnt;
    logic [26:0]   obs;

    int total = 0;
    int bad = 0;
    int prev_cnt = 0;
    int prev_ord = 0;

    fixed_subframe_controller #(.PIPE_LATENCY(LAT), .BLOCK_W(BW)) dut (
        .iClock(clk),
        .iReset(rst),
        .iStart(start),
        .iOrder(ord),
        .iBlockSize(blk),
        .iResidualValid(rv),
        .oResidualReady(o_ready),
        .oWarmup(o_warm),
        .oDecReset(o_dres),
        .oDecEnable(o_en),
        .oDecOrder(o_order),
        .oOutValid(o_outv),
        .oSampleCount(o_cnt),
        .oBusy(o_busy),
        .oDone(o_done),
        .oError(o_err)
    );

    always #5 clk = ~clk;

    assign obs = {o_busy, o_dres, o_en, o_ready, o_warm, o_outv,
                  o_done, o_err, o_order, o_cnt};

    // Reset with a simultaneous legal start: reset must win.
    task automatic test_reset();
        rst = 1'b1; start = 1'b1; ord = 3'd3; blk = 16'd8; rv = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (obs !== 27'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", obs, 27'd0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; rv = 1'b0;
        #1;
        total++;
        if (obs !== 27'd0) begin
            bad++;
            $display("FAIL reset_release got=%h want=%h", obs, 27'd0);
        end
        prev_cnt = 0;
        prev_ord = 0;
    endtask

    // Illegal starts: one error pulse each, never busy.
    task automatic test_errors();
        logic [2:0]  eo [4] = '{3'd5, 3'd3, 3'd0, 3'd7};
        logic [15:0] eb [4] = '{16'd8, 16'd2, 16'd0, 16'd100};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b1; ord = eo[k]; blk = eb[k]; rv = 1'($urandom_range(0, 1));
            #1;
            total++;
            if ({o_busy, o_err} !== 2'b00) begin
                bad++;
                $display("FAIL err_req%0d busy,err got=%b want=00", k, {o_busy, o_err});
            end
            @(negedge clk);
            start = 1'b0;
            #1;
            total++;
            if ({o_busy, o_err, o_order, o_cnt} !== {2'b01, 3'(prev_ord), 16'(prev_cnt)}) begin
                bad++;
                $display("FAIL err_pulse%0d got=%h want=%h", k,
                         {o_busy, o_err, o_order, o_cnt},
                         {2'b01, 3'(prev_ord), 16'(prev_cnt)});
            end
        end
    endtask

    // One subframe; mode 0=always valid, 1=toggle, 2=random.
    // rst_acc>0 resets the cycle after that accept; poke restarts mid-run.
    task automatic run_block(input string name, input int o, input int b,
                             input int mode, input int rst_acc, input bit poke);
        int  v[$];
        int  acc[$];
        int  e[$];
        int  outs[$];
        int  p, last, done_i, rst_cyc, nacc, nout, npulse, ndone, cnt_e, ord_e;
        bit  bb, vd, run_e, drain_e, en_e, outv_e, was_reset;
        logic [26:0] exp;

        p = 0;
        while (acc.size() < b) begin
            case (mode)
                0:       bb = 1'b1;
                1:       bb = (p % 2 == 0);
                default: bb = ($urandom_range(0, 3) != 0);
            endcase
            v.push_back(int'(bb));
            if (bb) acc.push_back(2 + p);
            p++;
        end
        last = acc[b-1];
        e = acc;
        for (int d = 1; d < LAT; d++) e.push_back(last + d);
        for (int k = 0; k < b; k++) outs.push_back(e[k+LAT-1] + 1);
        done_i = outs[b-1];
        rst_cyc = (rst_acc > 0) ? acc[rst_acc-1] + 1 : -1;
        npulse = 0; ndone = 0; was_reset = 1'b0;

        for (int i = 0; i <= done_i + 1; i++) begin
            @(negedge clk);
            vd = (i >= 2 && i - 2 < v.size()) ? (v[i-2] != 0) : 1'($urandom_range(0, 1));
            rv = vd;
            rst = (i == rst_cyc);
            start = (i == 0) || (poke && i == 4) || (i == rst_cyc);
            if (i == 0) begin
                ord = 3'(o); blk = 16'(b);
            end else if (i == rst_cyc) begin
                ord = 3'd1; blk = 16'd3;
            end else begin
                ord = 3'($urandom_range(0, 7)); blk = 16'($urandom);
            end
            #1;
            if (rst_cyc >= 0 && i == rst_cyc + 1) begin
                exp = '0;
                was_reset = 1'b1;
            end else begin
                run_e   = (i >= 2 && i <= last);
                drain_e = (i > last && i < done_i);
                en_e    = (run_e && vd) || drain_e;
                nacc = 0;
                foreach (acc[k]) if (acc[k] < i) nacc++;
                nout = 0; outv_e = 1'b0;
                foreach (outs[k]) begin
                    if (outs[k] <= i) nout++;
                    if (outs[k] == i) outv_e = 1'b1;
                end
                cnt_e = (i <= 1) ? prev_cnt : nout;
                ord_e = (i == 0) ? prev_ord : o;
                exp = {(i >= 1 && i <= done_i), (i == 1), en_e, run_e,
                       (run_e && vd && nacc < o), outv_e, (i == done_i),
                       1'b0, 3'(ord_e), 16'(cnt_e)};
            end
            if (o_outv === 1'b1) npulse++;
            if (o_done === 1'b1) ndone++;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h want=%h", name, i, obs, exp);
            end
            if (was_reset) break;
        end
        rst = 1'b0; start = 1'b0;

        if (was_reset) begin
            prev_cnt = 0; prev_ord = 0;
        end else begin
            total++;
            if (npulse != b || ndone != 1) begin
                bad++;
                $display("FAIL %s_totals outs=%0d done=%0d want outs=%0d done=1",
                         name, npulse, ndone, b);
            end
            prev_cnt = b; prev_ord = o;
        end
    endtask

    initial begin
        int ro, rb;
        test_reset();
        test_errors();
        run_block("o3b8", 3, 8, 0, 0, 1'b0);
        run_block("o2b6_toggle", 2, 6, 1, 0, 1'b0);
        run_block("o0b1", 0, 1, 0, 0, 1'b0);
        run_block("o4b4", 4, 4, 2, 0, 1'b0);
        run_block("reset_mid_run", 2, 10, 2, 4, 1'b0);
        run_block("after_reset", 3, 10, 2, 0, 1'b0);
        run_block("reset_mid_drain", 1, 5, 0, 5, 1'b0);
        run_block("start_in_run", 1, 7, 2, 0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            ro = $urandom_range(0, 4);
            rb = $urandom_range((ro == 0) ? 1 : ro, 20);
            run_block($sformatf("rand%0d", n), ro, rb, 2, 0, 1'($urandom_range(0, 1)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
